// File: rtl/regfile_vx_if.sv
// rtl/regfile_vx_if.sv - read, write and stream-fill bus of the vector register file
interface regfile_vx_if #(
    parameter int WIDTH        = 24,
    parameter int REGNUM       = 16,
    parameter int LANES        = 8,
    parameter int ADDRESSWIDTH = 4,
    parameter int INDEXWIDTH   = 3
) ();
    logic [ADDRESSWIDTH-1:0]  ra1;
    logic [ADDRESSWIDTH-1:0]  ra2;
    logic [INDEXWIDTH-1:0]    ridx;
    logic [WIDTH-1:0]         pc;
    logic [LANES*WIDTH-1:0]   rd1_v;
    logic [LANES*WIDTH-1:0]   rd2_v;
    logic [WIDTH-1:0]         rd1_s;
    logic [WIDTH-1:0]         rd2_s;
    logic                     we;
    logic                     wvec;
    logic [ADDRESSWIDTH-1:0]  wa;
    logic [INDEXWIDTH-1:0]    widx;
    logic [LANES-1:0]         wmask;
    logic [WIDTH-1:0]         wd_s;
    logic [LANES*WIDTH-1:0]   wd_v;
    logic                     st_start;
    logic [ADDRESSWIDTH-1:0]  st_reg;
    logic                     st_valid;
    logic [WIDTH-1:0]         st_data;
    logic                     st_ready;
    logic                     st_done;
    logic [REGNUM-1:0]        busy;
    logic                     wr_err;

    modport master (
        output ra1, ra2, ridx, pc, we, wvec, wa, widx, wmask, wd_s, wd_v,
               st_start, st_reg, st_valid, st_data,
        input  rd1_v, rd2_v, rd1_s, rd2_s, st_ready, st_done, busy, wr_err
    );

    modport slave (
        input  ra1, ra2, ridx, pc, we, wvec, wa, widx, wmask, wd_s, wd_v,
               st_start, st_reg, st_valid, st_data,
        output rd1_v, rd2_v, rd1_s, rd2_s, st_ready, st_done, busy, wr_err
    );
endinterface

// File: rtl/regfile_vx.sv
// rtl/regfile_vx.sv - vector register file with masked write port and element-serial stream fill
module regfile_vx #(
    parameter int WIDTH        = 24,
    parameter int REGNUM       = 16,
    parameter int LANES        = 8,
    parameter int ADDRESSWIDTH = 4,
    parameter int INDEXWIDTH   = 3,
    parameter int PC_ALIAS     = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_vx_if.slave    bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    logic [WIDTH-1:0]        rf_q [REGNUM][LANES];
    state_t                  state_q;
    logic [ADDRESSWIDTH-1:0] tgt_q;
    logic [INDEXWIDTH-1:0]   cnt_q;
    logic [REGNUM-1:0]       busy_q;
    logic                    st_ready_q;
    logic                    st_done_q;
    logic                    wr_err_q;

    logic [LANES*WIDTH-1:0]  rd1_v, rd2_v;
    logic [WIDTH-1:0]        rd1_s, rd2_s;
    logic                    wp_hit, wp_block;

    always_comb begin
        rd1_v = '0;
        rd2_v = '0;
        rd1_s = '0;
        rd2_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(bus.ra1) < REGNUM) rd1_v[i*WIDTH +: WIDTH] = rf_q[bus.ra1][i];
            if (int'(bus.ra2) < REGNUM) rd2_v[i*WIDTH +: WIDTH] = rf_q[bus.ra2][i];
        end
        if (PC_ALIAS != 0 && int'(bus.ra1) == REGNUM-1)
            rd1_s = bus.pc;
        else if (int'(bus.ra1) < REGNUM && int'(bus.ridx) < LANES)
            rd1_s = rf_q[bus.ra1][bus.ridx];
        if (PC_ALIAS != 0 && int'(bus.ra2) == REGNUM-1)
            rd2_s = bus.pc;
        else if (int'(bus.ra2) < REGNUM && int'(bus.ridx) < LANES)
            rd2_s = rf_q[bus.ra2][bus.ridx];
    end

    // The register currently being filled is owned by the stream; write-port hits on it are dropped.
    assign wp_hit   = bus.we && (int'(bus.wa) < REGNUM);
    assign wp_block = wp_hit && (state_q == STREAM) && (bus.wa == tgt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REGNUM; r++)
                for (int i = 0; i < LANES; i++)
                    rf_q[r][i] <= '0;
            state_q    <= IDLE;
            tgt_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= '0;
            st_ready_q <= 1'b0;
            st_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            st_done_q <= 1'b0;
            wr_err_q  <= wp_block;
            if (wp_hit && !wp_block) begin
                if (bus.wvec) begin
                    for (int i = 0; i < LANES; i++)
                        if (bus.wmask[i]) rf_q[bus.wa][i] <= bus.wd_v[i*WIDTH +: WIDTH];
                end else if (int'(bus.widx) < LANES) begin
                    rf_q[bus.wa][bus.widx] <= bus.wd_s;
                end
            end
            case (state_q)
                IDLE: begin
                    if (bus.st_start && int'(bus.st_reg) < REGNUM) begin
                        tgt_q              <= bus.st_reg;
                        busy_q[bus.st_reg] <= 1'b1;
                        cnt_q              <= '0;
                        st_ready_q         <= 1'b1;
                        state_q            <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.st_valid) begin
                        rf_q[tgt_q][cnt_q] <= bus.st_data;
                        if (int'(cnt_q) == LANES-1) begin
                            busy_q[tgt_q] <= 1'b0;
                            st_ready_q    <= 1'b0;
                            st_done_q     <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd1_v    = rd1_v;
    assign bus.rd2_v    = rd2_v;
    assign bus.rd1_s    = rd1_s;
    assign bus.rd2_s    = rd2_s;
    assign bus.st_ready = st_ready_q;
    assign bus.st_done  = st_done_q;
    assign bus.busy     = busy_q;
    assign bus.wr_err   = wr_err_q;
endmodule

// File: doc/regfile_vx.md
Name: regfile_vx

Overview:
- Parametrised vector register file for the vector datapath.
- Two combinational read ports, each returning a full vector plus one selected scalar element.
- One write port supporting lane-masked vector writes and single-element scalar writes.
- Adds an element-serial streaming fill port, used by the memory/load unit, driven by a small FSM with valid/ready handshake and a per-register busy scoreboard.

Parameters:
WIDTH, 24, element width in bits
REGNUM, 16, number of vector registers
LANES, 8, elements per vector register
ADDRESSWIDTH, 4, register address width (>= clog2(REGNUM))
INDEXWIDTH, 3, element index width (>= clog2(LANES))
PC_ALIAS, 1, when 1, scalar reads of register REGNUM-1 return pc

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ra1, ra2  in  ADDRESSWIDTH  read addresses
ridx  in  INDEXWIDTH  element index for scalar reads
pc  in  WIDTH  program counter for alias reads
rd1_v, rd2_v  out  LANES*WIDTH  vector read data, lane i at bits [i*WIDTH +: WIDTH]
rd1_s, rd2_s  out  WIDTH  scalar read data
we  in  1  write enable
wvec  in  1  1 = vector write, 0 = scalar element write
wa  in  ADDRESSWIDTH  write address
widx  in  INDEXWIDTH  element index for scalar write
wmask  in  LANES  lane enables for vector write
wd_s  in  WIDTH  scalar write data
wd_v  in  LANES*WIDTH  vector write data
st_start  in  1  begin stream fill
st_reg  in  ADDRESSWIDTH  stream target register
st_valid  in  1  stream element valid
st_data  in  WIDTH  stream element
st_ready  out  1  stream element accepted when st_valid & st_ready
st_done  out  1  one-cycle pulse after last element written
busy  out  REGNUM  bit r = register r is a stream target
wr_err  out  1  one-cycle pulse: write port write dropped

Behaviour:
- Reset (async, rst_n=0): all registers cleared to 0; FSM to IDLE; st_ready=0, st_done=0, busy=0, wr_err=0. Read outputs reflect cleared contents. Reset mid-stream abandons the stream with no st_done.
- Reads are purely combinational. A write is visible on reads the cycle after the write edge; same-cycle read returns old data.
- rdN_s = rf[raN][ridx], except pc when PC_ALIAS=1 and raN==REGNUM-1.
- ridx/widx >= LANES: read returns 0, write is ignored.
- Write port, registered, active when we=1:
  - wvec=1: for each lane i with wmask[i]=1, rf[wa][i] <= wd_v lane i; other lanes hold.
  - wvec=0: rf[wa][widx] <= wd_s.
  - wa >= REGNUM: write ignored, no error.
- FSM states: IDLE, STREAM.
  - IDLE: st_ready=0. st_start=1 latches st_reg into tgt, sets busy[tgt], clears lane counter cnt, goes to STREAM.
  - STREAM: st_ready=1. Each cycle with st_valid=1: rf[tgt][cnt] <= st_data, cnt increments.
  - When the element with cnt==LANES-1 is accepted: next cycle is IDLE, st_done=1 for one cycle, busy[tgt] cleared on the same edge.
  - st_start while in STREAM is ignored.
  - st_valid=0 stalls indefinitely without timeout.
- Conflicts:
  - A write-port write whose wa equals tgt while in STREAM is dropped, and wr_err pulses the next cycle.
  - A write-port write to a different register in the same cycle as a stream element write: both take effect.
- Back-to-back streams: st_start is accepted in the cycle st_done is high, because the FSM is in IDLE then. Minimum stream length is LANES+1 cycles including the start cycle.

Test Plan:
- Reset then read: rst_n=0 with ra1=3 -> rd1_v=0 and rd1_s=0 immediately; ra1=15, pc=0x000100 -> rd1_s=0x000100.
- Masked vector write: we=1, wvec=1, wa=2, wd_v lane i = i+1, wmask=8'b1010_1010 -> next cycle rd1_v (ra1=2) has lanes 1,3,5,7 = 2,4,6,8 and all other lanes 0; scalar read ridx=5 gives 6.
- Scalar write and read-during-write: we=1, wvec=0, wa=4, widx=7, wd_s=0xABCDEF with ra1=4, ridx=7 in the same cycle -> rd1_s=0 that cycle, 0xABCDEF the next.
- Stream with stalls: st_start with st_reg=6, then 8 elements 0x10..0x17 with st_valid low for 2 cycles midway -> busy[6]=1 throughout; st_done pulses once, 11 cycles after st_start; rd2_v (ra2=6) lanes = 0x10..0x17; busy[6]=0.
- Conflict: during a stream to reg 6, write-port writes to reg 6 and reg 9 -> reg 6 is unchanged by the write port and wr_err pulses once; reg 9 is written.
- Async reset mid-stream: rst_n low after 3 stream elements -> busy=0, st_ready=0, all registers 0, no st_done; a subsequent st_start works normally.
